tick_divider_multi: RTL and testbench

Parametrised, multi-channel successor to the fixed 50 MHz-to-1 Hz tick generator. Each channel divides the system clock by a runtime-loadable divisor and produces two outputs: a one-cycle clock-enable tick and a near-50%-duty square wave. Each channel runs either periodically or as a one-shot timer. Ticks feed counters and display logic as clock enables, never as clocks.

---
 rtl/tick_divider_multi_if.sv | 35 +++
 rtl/tick_divider_multi.sv | 165 ++++++++++++++++
 tb/tb_tick_divider_multi.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/tick_divider_multi_if.sv
// Control and status bundle for tick_divider_multi.
//   i_ch_en    per-channel enable (low holds the channel idle)
//   i_oneshot  per-channel mode: 0 = periodic, 1 = one-shot
//   i_start    one-cycle pulse, arms or retriggers a one-shot channel
//   i_load     one-cycle pulse, captures i_div into the channel's shadow divisor
//   i_div      shared divisor value
//   i_sync_clr restarts all enabled channels phase-aligned
//   o_tick     one-cycle clock-enable pulse at each period end
//   o_sq       square wave, high for the first ceil(D/2) counts
//   o_busy     one-shot channel armed and counting
// master = driver of the controls, slave = the divider.
interface tick_divider_multi_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 26
);
    logic [NUM_CH-1:0] i_ch_en;
    logic [NUM_CH-1:0] i_oneshot;
    logic [NUM_CH-1:0] i_start;
    logic [NUM_CH-1:0] i_load;
    logic [CNT_W-1:0]  i_div;
    logic              i_sync_clr;
    logic [NUM_CH-1:0] o_tick;
    logic [NUM_CH-1:0] o_sq;
    logic [NUM_CH-1:0] o_busy;

    modport master (
        output i_ch_en, i_oneshot, i_start, i_load, i_div, i_sync_clr,
        input  o_tick, o_sq, o_busy
    );

    modport slave (
        input  i_ch_en, i_oneshot, i_start, i_load, i_div, i_sync_clr,
        output o_tick, o_sq, o_busy
    );
endinterface

// File: rtl/tick_divider_multi.sv
// Multi-channel clock divider producing clock-enable ticks and square waves.
// Each channel divides i_clk by a runtime-loadable divisor D (clamped to >= 2),
// running either periodically or as a retriggerable one-shot.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset (deassertion synchronised internally)
//   bus      tick_divider_multi_if.slave control/status bundle

// One divider channel. The counter runs 0..D-1; all outputs are registered
// from next-state values so they line up with the counter.
module tick_divider_ch #(
    parameter int               CNT_W = 26,
    parameter logic [CNT_W-1:0] DEF_D = CNT_W'(2)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_oneshot,
    input  logic             i_start,
    input  logic             i_load,
    input  logic             i_sync_clr,
    input  logic [CNT_W-1:0] i_div,
    output logic             o_tick,
    output logic             o_sq,
    output logic             o_busy
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             busy_q, busy_d;
    logic             wrap;

    function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] v);
        return (v < CNT_W'(2)) ? CNT_W'(2) : v;
    endfunction

    // ceil(d/2) without needing an extra bit
    function automatic logic [CNT_W-1:0] half(input logic [CNT_W-1:0] d);
        return (d >> 1) + {{(CNT_W-1){1'b0}}, d[0]};
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= DEF_D;
            shadow_q <= DEF_D;
            mode_q   <= 1'b0;
            tick_q   <= 1'b0;
            sq_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            shadow_q <= shadow_d;
            mode_q   <= mode_d;
            tick_q   <= tick_d;
            sq_q     <= sq_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        mode_d   = mode_q;
        tick_d   = 1'b0;
        shadow_d = i_load ? clamp(i_div) : shadow_q;
        wrap     = (state_q == RUN) && (cnt_q == div_q - CNT_W'(1));

        // shadow_d (not shadow_q) is applied so a load landing on the same
        // edge as a wrap already governs the period that starts there.
        if (!i_en) begin
            state_d = IDLE;
            cnt_d   = '0;
            div_d   = shadow_d;
            mode_d  = i_oneshot;
        end else if (state_q == IDLE) begin
            // Periodic channels leave IDLE on the first enabled edge; one-shots
            // wait for i_start. Either way counting begins at 0 on that edge.
            cnt_d  = '0;
            div_d  = shadow_d;
            mode_d = i_oneshot;
            if (!i_oneshot || i_start) state_d = RUN;
        end else if (i_sync_clr) begin
            cnt_d = '0;
            div_d = shadow_d;
        end else if (i_start && mode_q) begin
            cnt_d = '0;
        end else if (wrap) begin
            // Mode changes requested while running are adopted here; a channel
            // that is (or becomes) one-shot returns to IDLE at its period end.
            cnt_d  = '0;
            tick_d = 1'b1;
            div_d  = shadow_d;
            mode_d = i_oneshot;
            if (i_oneshot) state_d = IDLE;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        busy_d = (state_d == RUN) && mode_d;
        sq_d   = (state_d == RUN) && (cnt_d < half(div_d));
    end

    assign o_tick = tick_q;
    assign o_sq   = sq_q;
    assign o_busy = busy_q;
endmodule

module tick_divider_multi #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 26,
    parameter int DEFAULT_DIV = 50000000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    tick_divider_multi_if.slave  bus
);
    localparam logic [CNT_W-1:0] DEF_RAW = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DEF_D   = (DEF_RAW < CNT_W'(2)) ? CNT_W'(2) : DEF_RAW;

    // Reset asserts asynchronously and releases two edges later, so no
    // channel flop sees a reset release close to a clock edge.
    logic [1:0]        rst_sync_q;
    logic              rst_int_n;
    logic [NUM_CH-1:0] tick_w, sq_w, busy_w;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        tick_divider_ch #(
            .CNT_W (CNT_W),
            .DEF_D (DEF_D)
        ) u_ch (
            .i_clk      (i_clk),
            .i_rst_n    (rst_int_n),
            .i_en       (bus.i_ch_en[k]),
            .i_oneshot  (bus.i_oneshot[k]),
            .i_start    (bus.i_start[k]),
            .i_load     (bus.i_load[k]),
            .i_sync_clr (bus.i_sync_clr),
            .i_div      (bus.i_div),
            .o_tick     (tick_w[k]),
            .o_sq       (sq_w[k]),
            .o_busy     (busy_w[k])
        );
    end

    assign bus.o_tick = tick_w;
    assign bus.o_sq   = sq_w;
    assign bus.o_busy = busy_w;
endmodule

// File: tb/tb_tick_divider_multi.sv
// Directed bench for tick_divider_multi: 2 channels, 8-bit counters,
// DEFAULT_DIV = 4. Inputs change 1 time unit after a rising edge and outputs
// are sampled at the same point, so "after edge n" is the registered state.
module tb_tick_divider_multi;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    tick_divider_multi_if #(.NUM_CH(2), .CNT_W(8)) bus ();

    tick_divider_multi #(
        .NUM_CH      (2),
        .CNT_W       (8),
        .DEFAULT_DIV (4)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.i_ch_en    = '0;
        bus.i_oneshot  = '0;
        bus.i_start    = '0;
        bus.i_load     = '0;
        bus.i_div      = '0;
        bus.i_sync_clr = 1'b0;

        // reset state
        step(); step();
        chk("rst tick", 32'(bus.o_tick), 0);
        chk("rst sq",   32'(bus.o_sq),   0);
        chk("rst busy", 32'(bus.o_busy), 0);
        rst_n = 1'b1;
        step(); step(); step();

        // 1: default D=4 periodic on ch0
        bus.i_ch_en = 2'b01;
        for (int n = 0; n <= 12; n++) begin
            step();
            chk($sformatf("t1 tick n=%0d", n), 32'(bus.o_tick[0]), 32'(n > 0 && n % 4 == 0));
            chk($sformatf("t1 sq n=%0d", n),   32'(bus.o_sq[0]),   32'(n % 4 < 2));
            chk($sformatf("t1 busy n=%0d", n), 32'(bus.o_busy[0]), 0);
        end

        // 2: load 5 mid-period (counter=1): period of 4 completes at edge 16,
        //    then ticks every 5 with 3 high / 2 low
        for (int n = 13; n <= 26; n++) begin
            bus.i_load = (n == 14) ? 2'b01 : 2'b00;
            bus.i_div  = 8'd5;
            step();
            if (n < 16) begin
                chk($sformatf("t2 tick n=%0d", n), 32'(bus.o_tick[0]), 0);
                chk($sformatf("t2 sq n=%0d", n),   32'(bus.o_sq[0]),   32'(n - 12 < 2));
            end else begin
                chk($sformatf("t2 tick n=%0d", n), 32'(bus.o_tick[0]), 32'((n - 16) % 5 == 0));
                chk($sformatf("t2 sq n=%0d", n),   32'(bus.o_sq[0]),   32'((n - 16) % 5 < 3));
            end
        end
        bus.i_load = 2'b00;

        // 3: divisor 0 loaded while disabled (immediate), then 1 loaded while
        //    running; both act as D=2
        bus.i_ch_en = 2'b00;
        bus.i_load  = 2'b01;
        bus.i_div   = 8'd0;
        step();
        chk("t3 dis tick", 32'(bus.o_tick[0]), 0);
        chk("t3 dis sq",   32'(bus.o_sq[0]),   0);
        bus.i_load  = 2'b00;
        bus.i_ch_en = 2'b01;
        for (int n = 0; n <= 12; n++) begin
            bus.i_load = (n == 7) ? 2'b01 : 2'b00;
            bus.i_div  = (n >= 7) ? 8'd1 : 8'd0;
            step();
            chk($sformatf("t3 tick n=%0d", n), 32'(bus.o_tick[0]), 32'(n > 0 && n % 2 == 0));
            chk($sformatf("t3 sq n=%0d", n),   32'(bus.o_sq[0]),   32'(n % 2 == 0));
        end
        bus.i_load = 2'b00;

        // 4: one-shot on ch1, D=6, then a retrigger at count 3
        bus.i_ch_en   = 2'b10;
        bus.i_oneshot = 2'b10;
        bus.i_load    = 2'b10;
        bus.i_div     = 8'd6;
        step();
        bus.i_load = 2'b00;
        step();
        chk("t4 idle busy", 32'(bus.o_busy[1]), 0);
        chk("t4 idle tick", 32'(bus.o_tick[1]), 0);
        for (int n = 0; n <= 9; n++) begin
            bus.i_start = (n == 0) ? 2'b10 : 2'b00;
            step();
            chk($sformatf("t4 busy n=%0d", n), 32'(bus.o_busy[1]), 32'(n < 6));
            chk($sformatf("t4 tick n=%0d", n), 32'(bus.o_tick[1]), 32'(n == 6));
            chk($sformatf("t4 sq n=%0d", n),   32'(bus.o_sq[1]),   32'(n < 3));
        end
        for (int n = 0; n <= 12; n++) begin
            int c;
            bus.i_start = (n == 0 || n == 4) ? 2'b10 : 2'b00;
            step();
            c = (n < 4) ? n : n - 4;
            chk($sformatf("t4r busy n=%0d", n), 32'(bus.o_busy[1]), 32'(n < 10));
            chk($sformatf("t4r tick n=%0d", n), 32'(bus.o_tick[1]), 32'(n == 10));
            chk($sformatf("t4r sq n=%0d", n),   32'(bus.o_sq[1]),   32'(n < 10 && c < 3));
        end
        bus.i_start = 2'b00;

        // 5: ch0 D=3, ch1 D=4 started a cycle apart, then sync_clr on the
        //    edge where ch0 would wrap
        bus.i_ch_en   = 2'b00;
        bus.i_oneshot = 2'b00;
        step();
        bus.i_load = 2'b01; bus.i_div = 8'd3; step();
        bus.i_load = 2'b10; bus.i_div = 8'd4; step();
        bus.i_load = 2'b00;
        bus.i_ch_en = 2'b01; step();
        bus.i_ch_en = 2'b11; step();
        step();
        bus.i_sync_clr = 1'b1;
        step();
        bus.i_sync_clr = 1'b0;
        chk("t5 sync tick", 32'(bus.o_tick), 0);
        chk("t5 sync sq",   32'(bus.o_sq),   32'(2'b11));
        for (int n = 1; n <= 24; n++) begin
            step();
            chk($sformatf("t5 tick0 n=%0d", n), 32'(bus.o_tick[0]), 32'(n % 3 == 0));
            chk($sformatf("t5 tick1 n=%0d", n), 32'(bus.o_tick[1]), 32'(n % 4 == 0));
            chk($sformatf("t5 sq0 n=%0d", n),   32'(bus.o_sq[0]),   32'(n % 3 < 2));
            chk($sformatf("t5 sq1 n=%0d", n),   32'(bus.o_sq[1]),   32'(n % 4 < 2));
        end

        // 6: async reset mid-period with o_sq high, then DEFAULT_DIV restored
        step();
        chk("t6 pre sq", 32'(bus.o_sq), 32'(2'b11));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 async tick", 32'(bus.o_tick), 0);
        chk("t6 async sq",   32'(bus.o_sq),   0);
        chk("t6 async busy", 32'(bus.o_busy), 0);
        bus.i_ch_en = 2'b00;
        step(); step();
        rst_n = 1'b1;
        step(); step(); step();
        bus.i_ch_en = 2'b01;
        for (int n = 0; n <= 8; n++) begin
            step();
            chk($sformatf("t6 tick n=%0d", n), 32'(bus.o_tick[0]), 32'(n > 0 && n % 4 == 0));
            chk($sformatf("t6 sq n=%0d", n),   32'(bus.o_sq[0]),   32'(n % 4 < 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
